// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_RX_LEN  = 3'd0,
    ST_RX_WORD = 3'd1,
    ST_WRITE   = 3'd2,
    ST_RX_CSUM = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

  localparam int HDR_LEN        = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_DEPTH  = 1024;

endpackage

// File: rtl/imem_loader_word_asm.sv
// Little-endian 4-byte word assembler: each byte enters at the top and the word
// shifts down, so after four bytes the first byte sits in bits [7:0].
module loader_word_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= 32'd0;
      r_cnt  <= 2'd0;
    end else if (i_clr) begin
      r_word <= 32'd0;
      r_cnt  <= 2'd0;
    end else if (i_shift) begin
      r_word <= {i_byte, r_word[31:8]};
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  // High while the byte being shifted in completes the word.
  assign o_full = i_shift && (r_cnt == LAST_BYTE);
  assign o_word = r_word;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length header + little-endian words over
// a byte stream, holding the core in reset until done. Optional trailing XOR
// checksum byte is enabled with the LOADER_CSUM_EN macro.
// Handshake: a byte moves on a rising clk edge when in_valid && in_ready;
// in_ready depends only on the current state, never on in_valid.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          start,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [31:0]   wd,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output logic [2:0]    o_dbg_state
);

  localparam logic [15:0] DEPTH16  = 16'(DEPTH);
  localparam logic        HDR_LAST = 1'(HDR_LEN - 1);

  state_e        r_state;
  logic          r_hdr_cnt;
  logic [15:0]   r_len;
  logic [15:0]   r_idx;
  logic          r_we;
  logic [AW-1:0] r_wa;
  logic          r_hold;
  logic          r_done;
  logic          r_err;
`ifdef LOADER_CSUM_EN
  logic [7:0]    r_csum;
`endif

  logic          w_accept;
  logic          w_restart;
  logic          w_shift;
  logic          w_full;
  logic [15:0]   w_len;
  logic [31:0]   w_word;

  assign in_ready  = (r_state == ST_RX_LEN) || (r_state == ST_RX_WORD) ||
                     (r_state == ST_RX_CSUM);
  assign w_accept  = in_valid && in_ready;
  assign w_restart = start && ((r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_shift   = w_accept && (r_state == ST_RX_WORD);
  assign w_len     = {in_data, r_len[7:0]};

  loader_word_asm u_word_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_restart),
    .i_shift (w_shift),
    .i_byte  (in_data),
    .o_word  (w_word),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RX_LEN;
      r_hdr_cnt <= 1'b0;
      r_len     <= 16'd0;
      r_idx     <= 16'd0;
      r_we      <= 1'b0;
      r_wa      <= '0;
      r_hold    <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef LOADER_CSUM_EN
      r_csum    <= 8'd0;
`endif
    end else begin
      r_we <= 1'b0;
`ifdef LOADER_CSUM_EN
      if (w_accept && (r_state != ST_RX_CSUM)) r_csum <= r_csum ^ in_data;
`endif
      case (r_state)
        ST_RX_LEN: begin
          if (w_accept) begin
            if (r_hdr_cnt != HDR_LAST) begin
              r_len[7:0] <= in_data;
              r_hdr_cnt  <= r_hdr_cnt + 1'b1;
            end else begin
              r_hdr_cnt <= 1'b0;
              r_len     <= w_len;
              if (w_len == 16'd0) begin
`ifdef LOADER_CSUM_EN
                r_state <= ST_RX_CSUM;
`else
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_hold  <= 1'b0;
`endif
              end else if (w_len > DEPTH16) begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
              end else begin
                r_state <= ST_RX_WORD;
              end
            end
          end
        end
        ST_RX_WORD: begin
          // The word register is complete at this edge, so we/wa line up with wd.
          if (w_full) begin
            r_state <= ST_WRITE;
            r_we    <= 1'b1;
            r_wa    <= AW'({r_idx, 2'b00});
          end
        end
        ST_WRITE: begin
          r_idx <= r_idx + 16'd1;
          if (r_idx == r_len - 16'd1) begin
`ifdef LOADER_CSUM_EN
            r_state <= ST_RX_CSUM;
`else
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_hold  <= 1'b0;
`endif
          end else begin
            r_state <= ST_RX_WORD;
          end
        end
        ST_RX_CSUM: begin
`ifdef LOADER_CSUM_EN
          if (w_accept) begin
            if (in_data == r_csum) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
`else
          r_state <= ST_ERR;
          r_err   <= 1'b1;
`endif
        end
        ST_DONE, ST_ERR: begin
          if (w_restart) begin
            r_state   <= ST_RX_LEN;
            r_hdr_cnt <= 1'b0;
            r_idx     <= 16'd0;
            r_hold    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef LOADER_CSUM_EN
            r_csum    <= 8'd0;
`endif
          end
        end
        default: begin
          r_state <= ST_RX_LEN;
        end
      endcase
    end
  end

  assign we          = r_we;
  assign wa          = r_wa;
  assign wd          = w_word;
  assign cpu_hold    = r_hold;
  assign done        = r_done;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule
